i2c_burst_ctrl: RTL and testbench
=================================

Name: i2c_burst_ctrl

Overview:
Command sequencer that sits directly upstream of the team's byte-level I2C master. It accepts one command per transfer (7-bit slave address, direction, byte count), buffers write bytes in an internal FIFO, and drives the master's ena/byte/address inputs. It consumes the master's per-byte end_trans strobe and received byte, and returns read bytes, a done pulse and an error pulse. The error pulse covers NACK, zero-length commands and the timeout watchdog.

Parameters:
CLK_FREQ, 100_000_000, system clock Hz
I2C_FREQ, 100_000, bus clock Hz; BIT_CYC = CLK_FREQ/I2C_FREQ
BITS_WAIT, 2, inter-byte wait bits used by the master; timeout sizing only
MAX_BYTES, 16, max bytes per command and write FIFO depth (power of 2)
MSB_FIRST, 1, drives m_msb_lsb
TIMEOUT_CYC, BIT_CYC*(BITS_WAIT+12), max cycles allowed between end_trans rises

Ports:
clk  in  1  clock
arstn  in  1  async active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_addr  in  7  slave address
cmd_rw  in  1  1=read, 0=write
cmd_len  in  $clog2(MAX_BYTES+1)  byte count
wr_valid  in  1  write-byte push
wr_data  in  8  write byte
wr_ready  out  1  FIFO not full
rd_valid  out  1  one-cycle pulse, read byte valid
rd_data  out  8  read byte
done  out  1  one-cycle pulse, command finished
err  out  1  one-cycle pulse, coincident with done
busy  out  1  state != IDLE
m_ena  out  1  to master ena_i2c
m_byte_2_send  out  8  to master byte_2_send
m_adrr_r_w  out  8  {addr, rw}
m_msb_lsb  out  1  constant MSB_FIRST
m_end_trans  in  1  from master
m_byte_received  in  8  from master

Behaviour:
- Reset: arstn is asynchronous, active-low; clock is clk. State IDLE; FIFO empty; all outputs 0 except cmd_ready=1 and wr_ready=1.
- et_rise = m_end_trans & ~et_q, where et_q is m_end_trans registered one cycle. et_q resets to 0.
- IDLE:
  - On cmd_valid, latch addr/rw/len into cmd regs and set m_adrr_r_w = {addr, rw}.
  - len==0: go to DONE with err=1; no bus activity.
  - Write command: go to WAIT_DATA.
  - Read command: go to RUN.
- WAIT_DATA: wait until FIFO count >= len. Then pop the FIFO head into m_byte_2_send and go to RUN.
- RUN:
  - m_ena=1.
  - idx counts et_rise events, starting at 0.
  - idx==0 is the address ACK; idx==k for 1<=k<=len is the ACK after data byte k-1.
  - On et_rise with 1<=idx<=len:
    - Read: rd_data <= m_byte_received and pulse rd_valid the next cycle.
    - Write with idx<len: pop the next FIFO byte into m_byte_2_send.
  - On et_rise with idx==len: drop m_ena in the same registered update, so it is low before the master's mid-ACK sample. Go to STOP_WAIT with err=0.
  - Watchdog: counter cleared on entry to RUN and on every et_rise.
    - If it reaches TIMEOUT_CYC, drop m_ena, set err_flag and go to STOP_WAIT.
    - A NACK returns the master to idle silently, so this watchdog is the only NACK detection.
- STOP_WAIT:
  - m_ena=0 for 2*BIT_CYC cycles so the master completes STOP or settles in idle.
  - If err_flag is set, flush the FIFO.
  - Then go to DONE.
- DONE: done=1 and err=err_flag for one cycle. Clear err_flag and go to IDLE.
- FIFO:
  - A push when full is ignored; wr_ready=0 when full.
  - Push and pop in the same cycle is allowed; count is unchanged.
  - Pointers wrap modulo MAX_BYTES.
- FIFO pushes during RUN are accepted; only bytes already present can be consumed.
- A cmd_valid while busy is ignored; cmd_ready is low.
- Asynchronous reset mid-transfer:
  - m_ena drops to 0 immediately and the FIFO empties.
  - The master is reset by the same arstn.
- m_byte_2_send holds its value outside RUN.

Decomposition:
- Package i2c_pkg:
  - burst_state_t enum {IDLE, WAIT_DATA, RUN, STOP_WAIT, DONE}.
  - Localparam function for BIT_CYC and for the TIMEOUT_CYC default.
  - I2C_ADDR_W=7.
- Sub-module i2c_byte_fifo (8-bit, depth MAX_BYTES, push/pop/count/full/empty/flush), instantiated once.

Test Plan:
- Write 3 bytes 0xA5, 0x3C, 0x01 to addr 0x50 against a master plus ACKing slave model.
  - Slave sees 0xA0, A5, 3C, 01 then STOP.
  - One done pulse with err=0; m_ena falls within 2 cycles of the 4th et_rise.
- Read 2 bytes from addr 0x48 with slave returning 0x12, 0x34.
  - rd_valid pulses twice with 0x12 then 0x34; done with err=0; m_adrr_r_w=0x91.
- Slave NACKs the address.
  - err=1 with done after TIMEOUT_CYC + 2*BIT_CYC cycles.
  - m_ena=0 from timeout; FIFO empty; no rd_valid.
- cmd_len=0 -> done and err the second cycle after accept; m_ena never rises.
- Write len=4 with only 2 bytes pushed -> stays in WAIT_DATA with m_ena=0.
  - Push 2 more -> transfer proceeds; push 17 bytes with MAX_BYTES=16 -> 17th ignored, wr_ready=0.
- Assert arstn low during the 2nd data byte -> next cycle m_ena=0, busy=0, cmd_ready=1, FIFO count 0.

Source files
------------

// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Package     : i2c_pkg
// Description : Shared types and timing helpers for the I2C burst controller.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DATA = 3'd1,
    RUN       = 3'd2,
    STOP_WAIT = 3'd3,
    DONE      = 3'd4
  } burst_state_t;

  // System clock cycles per I2C bit period
  function automatic int bit_cyc(input int clk_freq, input int i2c_freq);
    return clk_freq / i2c_freq;
  endfunction

  // Longest legal gap between end_trans rises: one byte, its ACK and the
  // master's inter-byte wait, with margin
  function automatic int timeout_cyc(input int clk_freq, input int i2c_freq,
                                     input int bits_wait);
    return bit_cyc(clk_freq, i2c_freq) * (bits_wait + 12);
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : i2c_byte_fifo
// Description : Byte FIFO holding write data ahead of the I2C master.
//               Pushes while full are dropped; flush empties it at once.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       arstn,
  input  logic                       flush,
  input  logic                       push,
  input  logic [7:0]                 din,
  input  logic                       pop,
  output logic [7:0]                 dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cw = $clog2(DEPTH + 1);

  logic [7:0]      r_mem [DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_cw-1:0] r_count;
  logic            w_push;
  logic            w_pop;

  assign full   = (r_count == c_cw'(DEPTH));
  assign empty  = (r_count == '0);
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign dout   = r_mem[r_rd_ptr];
  assign count  = r_count;

  // Storage array; no reset needed since count gates every read
  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= din;
  end

  // Pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cw'(1);
        2'b01:   r_count <= r_count - c_cw'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2c_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : i2c_burst_ctrl
// Description : Command sequencer in front of the byte-level I2C master.
//               Takes one address/direction/length command, feeds write bytes
//               from a FIFO, returns read bytes, and reports done/err.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_burst_ctrl
  import i2c_pkg::*;
#(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int I2C_FREQ    = 100_000,
  parameter int BITS_WAIT   = 2,
  parameter int MAX_BYTES   = 16,
  parameter int MSB_FIRST   = 1,
  parameter int TIMEOUT_CYC = timeout_cyc(CLK_FREQ, I2C_FREQ, BITS_WAIT)
) (
  input  logic                           clk,
  input  logic                           arstn,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [I2C_ADDR_W-1:0]          cmd_addr,
  input  logic                           cmd_rw,
  input  logic [$clog2(MAX_BYTES+1)-1:0] cmd_len,
  input  logic                           wr_valid,
  input  logic [7:0]                     wr_data,
  output logic                           wr_ready,
  output logic                           rd_valid,
  output logic [7:0]                     rd_data,
  output logic                           done,
  output logic                           err,
  output logic                           busy,
  output logic                           m_ena,
  output logic [7:0]                     m_byte_2_send,
  output logic [7:0]                     m_adrr_r_w,
  output logic                           m_msb_lsb,
  input  logic                           m_end_trans,
  input  logic [7:0]                     m_byte_received
);

  localparam int c_bit_cyc = bit_cyc(CLK_FREQ, I2C_FREQ);
  localparam int c_len_w   = $clog2(MAX_BYTES + 1);
  localparam int c_wd_w    = $clog2(TIMEOUT_CYC + 1);
  localparam int c_sw_w    = $clog2(2 * c_bit_cyc + 1);

  localparam logic [2:0] c_idle      = IDLE;
  localparam logic [2:0] c_wait_data = WAIT_DATA;
  localparam logic [2:0] c_run       = RUN;
  localparam logic [2:0] c_stop_wait = STOP_WAIT;
  localparam logic [2:0] c_done      = DONE;

  logic [2:0]         r_state;
  logic               r_rw;
  logic [c_len_w-1:0] r_len;
  logic [c_len_w-1:0] r_idx;
  logic [c_wd_w-1:0]  r_wd;
  logic [c_sw_w-1:0]  r_sw;
  logic               r_err_flag;
  logic               r_et_q;

  logic               w_et_rise;
  logic               w_data_ack;
  logic               w_pop;
  logic               w_flush;
  logic [7:0]         w_fifo_dout;
  logic [c_len_w-1:0] w_fifo_count;
  logic               w_fifo_full;
  logic               w_fifo_empty;

  assign cmd_ready  = (r_state == c_idle);
  assign busy       = (r_state != c_idle);
  assign wr_ready   = ~w_fifo_full;
  assign m_msb_lsb  = (MSB_FIRST != 0);
  assign w_et_rise  = m_end_trans & ~r_et_q;
  // idx 0 is the address ACK; 1..len are the ACKs after each data byte
  assign w_data_ack = (r_idx != '0) && (r_idx <= r_len);
  assign w_pop      = ((r_state == c_wait_data) && (w_fifo_count >= r_len)) ||
                      ((r_state == c_run) && w_et_rise && !r_rw &&
                       (r_idx != '0) && (r_idx < r_len));
  // After a timeout or NACK the leftover write bytes belong to a dead command
  assign w_flush    = (r_state == c_stop_wait) && r_err_flag;

  i2c_byte_fifo #(
    .DEPTH (MAX_BYTES)
  ) u_fifo (
    .clk   (clk),
    .arstn (arstn),
    .flush (w_flush),
    .push  (wr_valid),
    .din   (wr_data),
    .pop   (w_pop),
    .dout  (w_fifo_dout),
    .count (w_fifo_count),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  // Delayed copy of end_trans for rising-edge detection
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) r_et_q <= 1'b0;
    else        r_et_q <= m_end_trans;
  end

  // Command sequencer, master drive and watchdog
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state       <= c_idle;
      r_rw          <= 1'b0;
      r_len         <= '0;
      r_idx         <= '0;
      r_wd          <= '0;
      r_sw          <= '0;
      r_err_flag    <= 1'b0;
      rd_valid      <= 1'b0;
      rd_data       <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
      m_ena         <= 1'b0;
      m_byte_2_send <= '0;
      m_adrr_r_w    <= '0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      case (r_state)
        c_idle: begin
          if (cmd_valid) begin
            r_rw       <= cmd_rw;
            r_len      <= cmd_len;
            m_adrr_r_w <= {cmd_addr, cmd_rw};
            if (cmd_len == '0) begin
              r_err_flag <= 1'b1;
              r_state    <= c_done;
            end else if (cmd_rw) begin
              m_ena   <= 1'b1;
              r_idx   <= '0;
              r_wd    <= '0;
              r_state <= c_run;
            end else begin
              r_state <= c_wait_data;
            end
          end
        end
        c_wait_data: begin
          if (w_fifo_count >= r_len) begin
            m_byte_2_send <= w_fifo_dout;
            m_ena         <= 1'b1;
            r_idx         <= '0;
            r_wd          <= '0;
            r_state       <= c_run;
          end
        end
        c_run: begin
          if (w_et_rise) begin
            r_idx <= r_idx + c_len_w'(1);
            r_wd  <= '0;
            if (w_data_ack && r_rw) begin
              rd_data  <= m_byte_received;
              rd_valid <= 1'b1;
            end
            if (w_pop) m_byte_2_send <= w_fifo_dout;
            // Drop ena now so the master sees it low at the mid-ACK sample
            if (r_idx == r_len) begin
              m_ena   <= 1'b0;
              r_sw    <= '0;
              r_state <= c_stop_wait;
            end
          end else if (r_wd == c_wd_w'(TIMEOUT_CYC - 1)) begin
            m_ena      <= 1'b0;
            r_err_flag <= 1'b1;
            r_sw       <= '0;
            r_state    <= c_stop_wait;
          end else begin
            r_wd <= r_wd + c_wd_w'(1);
          end
        end
        c_stop_wait: begin
          if (r_sw == c_sw_w'(2 * c_bit_cyc - 1)) r_state <= c_done;
          else                                    r_sw    <= r_sw + c_sw_w'(1);
        end
        c_done: begin
          done       <= 1'b1;
          err        <= r_err_flag;
          r_err_flag <= 1'b0;
          r_state    <= c_idle;
        end
        default: begin
          m_ena   <= 1'b0;
          r_state <= c_idle;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_burst_ctrl
// Description : Self-checking bench for i2c_burst_ctrl with a behavioural
//               byte-level master and slave; scoreboard queues for bus bytes,
//               read bytes and done/err results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_burst_ctrl;

  localparam int CLK_FREQ  = 1_000_000;
  localparam int I2C_FREQ  = 100_000;
  localparam int BITS_WAIT = 2;
  localparam int MAX_BYTES = 16;
  localparam int B         = CLK_FREQ / I2C_FREQ;
  localparam int T         = B * (BITS_WAIT + 12);
  localparam int STOP_TOK  = 256;

  logic       clk = 1'b0;
  logic       arstn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [6:0] cmd_addr = '0;
  logic       cmd_rw = 1'b0;
  logic [4:0] cmd_len = '0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       done;
  logic       err;
  logic       busy;
  logic       m_ena;
  logic [7:0] m_byte_2_send;
  logic [7:0] m_adrr_r_w;
  logic       m_msb_lsb;
  logic       m_end_trans = 1'b0;
  logic [7:0] m_byte_received = '0;

  int checks = 0;
  int failures = 0;
  int exp_bus[$];
  int exp_rd[$];
  int exp_done[$];

  logic [7:0] slave_rd [2];
  bit         slave_nack = 1'b0;
  bit         m_abort = 1'b0;

  int   cyc = 0, et_cnt = 0, t_et_last = 0, t_ena_rise = 0, t_ena_fall = 0;
  int   t_done = 0, ena_rises = 0, rises0 = 0;
  logic et_prev = 1'b0, ena_prev = 1'b0;

  i2c_burst_ctrl #(
    .CLK_FREQ  (CLK_FREQ),
    .I2C_FREQ  (I2C_FREQ),
    .BITS_WAIT (BITS_WAIT),
    .MAX_BYTES (MAX_BYTES),
    .MSB_FIRST (1)
  ) dut (
    .clk             (clk),
    .arstn           (arstn),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_addr        (cmd_addr),
    .cmd_rw          (cmd_rw),
    .cmd_len         (cmd_len),
    .wr_valid        (wr_valid),
    .wr_data         (wr_data),
    .wr_ready        (wr_ready),
    .rd_valid        (rd_valid),
    .rd_data         (rd_data),
    .done            (done),
    .err             (err),
    .busy            (busy),
    .m_ena           (m_ena),
    .m_byte_2_send   (m_byte_2_send),
    .m_adrr_r_w      (m_adrr_r_w),
    .m_msb_lsb       (m_msb_lsb),
    .m_end_trans     (m_end_trans),
    .m_byte_received (m_byte_received)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- master + slave model (drives on negedge) ----------------
  task automatic mcyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!arstn) begin
        m_abort     = 1'b1;
        m_end_trans = 1'b0;
        return;
      end
    end
  endtask

  task automatic slave_see(input int v);
    chk("bus_queued", 32'(exp_bus.size() != 0), 32'd1);
    if (exp_bus.size() != 0) chk("bus_byte", v, exp_bus.pop_front());
  endtask

  task automatic ack_phase(output bit go);
    go = 1'b0;
    m_end_trans = 1'b1;
    mcyc(B / 2);
    if (m_abort) return;
    go = m_ena;
    mcyc(B - B / 2);
    m_end_trans = 1'b0;
  endtask

  task automatic run_transfer();
    logic [7:0] a;
    bit go;
    int n;
    a = m_adrr_r_w;
    n = 0;
    slave_see(a);
    mcyc(8 * B);
    if (m_abort) return;
    if (slave_nack) begin
      for (int i = 0; i < 4 * T && m_ena; i++) begin
        mcyc(1);
        if (m_abort) return;
      end
      return;
    end
    ack_phase(go);
    if (m_abort) return;
    while (go) begin
      if (!a[0]) begin
        slave_see(m_byte_2_send);
        mcyc(8 * B);
      end else begin
        mcyc(8 * B);
        m_byte_received = slave_rd[n & 1];
      end
      if (m_abort) return;
      n++;
      ack_phase(go);
      if (m_abort) return;
    end
    slave_see(STOP_TOK);
  endtask

  initial begin : master_model
    forever begin
      @(negedge clk);
      m_abort = 1'b0;
      if (arstn && m_ena) run_transfer();
    end
  end

  // ---------------- output monitor / scoreboard ----------------
  always @(posedge clk) begin
    #1;
    cyc++;
    if (m_end_trans && !et_prev) begin
      et_cnt++;
      t_et_last = cyc;
    end
    et_prev = m_end_trans;
    if (m_ena && !ena_prev) begin
      ena_rises++;
      t_ena_rise = cyc;
    end
    if (!m_ena && ena_prev) t_ena_fall = cyc;
    ena_prev = m_ena;
    if (done) begin
      t_done = cyc;
      chk("done_queued", 32'(exp_done.size() != 0), 32'd1);
      if (exp_done.size() != 0) chk("done_err", 32'(err), exp_done.pop_front());
    end
    if (err) chk("err_with_done", 32'(done), 32'd1);
    if (rd_valid) begin
      chk("rd_queued", 32'(exp_rd.size() != 0), 32'd1);
      if (exp_rd.size() != 0) chk("rd_data", rd_data, exp_rd.pop_front());
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_byte(input logic [7:0] d);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic issue_cmd(input logic [6:0] a, input logic rw, input logic [4:0] len);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_rw    = rw;
    cmd_len   = len;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      #2;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, 32'(seen), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_et(input int n, input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      #2;
      if (et_cnt >= n) begin
        seen = 1'b1;
        break;
      end
    end
    chk("et_wait", 32'(seen), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stimulus
    slave_rd[0] = 8'h12;
    slave_rd[1] = 8'h34;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_busy_ena_done_err_rdv", {busy, m_ena, done, err, rd_valid}, 0);
    chk("rst_adrr", m_adrr_r_w, 0);
    chk("msb_lsb", m_msb_lsb, 1);
    arstn = 1'b1;

    // Write 3 bytes to 0x50
    push_byte(8'hA5); push_byte(8'h3C); push_byte(8'h01);
    exp_bus.push_back(8'hA0); exp_bus.push_back(8'hA5); exp_bus.push_back(8'h3C);
    exp_bus.push_back(8'h01); exp_bus.push_back(STOP_TOK);
    exp_done.push_back(0);
    et_cnt = 0;
    issue_cmd(7'h50, 1'b0, 5'd3);
    wait_done("t1_done_seen", 3000);
    chk("t1_et_count", et_cnt, 4);
    chk("t1_ena_fall_lag", 32'((t_ena_fall >= t_et_last) && (t_ena_fall - t_et_last <= 2)), 1);

    // Read 2 bytes from 0x48
    exp_rd.push_back(8'h12); exp_rd.push_back(8'h34);
    exp_bus.push_back(8'h91); exp_bus.push_back(STOP_TOK);
    exp_done.push_back(0);
    issue_cmd(7'h48, 1'b1, 5'd2);
    wait_done("t2_done_seen", 3000);
    chk("t2_adrr", m_adrr_r_w, 8'h91);
    chk("t2_rd_all", exp_rd.size(), 0);

    // Address NACK -> watchdog
    slave_nack = 1'b1;
    push_byte(8'h11); push_byte(8'h22);
    exp_bus.push_back(8'hA0);
    exp_done.push_back(1);
    issue_cmd(7'h50, 1'b0, 5'd1);
    wait_done("t3_done_seen", 1000);
    chk("t3_ena_high", 32'((t_ena_fall - t_ena_rise >= T) && (t_ena_fall - t_ena_rise <= T + 1)), 1);
    chk("t3_done_delay", 32'((t_done - t_ena_rise >= T + 2 * B) && (t_done - t_ena_rise <= T + 2 * B + 2)), 1);
    chk("t3_ena_low", m_ena, 0);
    slave_nack = 1'b0;

    // Zero-length command
    rises0 = ena_rises;
    exp_done.push_back(1);
    issue_cmd(7'h20, 1'b0, 5'd0);
    chk("t4_done_c1", {done, busy}, 2'b01);
    @(posedge clk); #2;
    chk("t4_done_err_c2", {done, err}, 2'b11);
    @(negedge clk);
    chk("t4_no_ena", ena_rises, rises0);

    // Stall in WAIT_DATA (also shows the NACK flush left nothing behind)
    push_byte(8'hC1); push_byte(8'hC2); push_byte(8'hC3);
    rises0 = ena_rises;
    issue_cmd(7'h3A, 1'b0, 5'd4);
    repeat (60) @(negedge clk);
    issue_cmd(7'h11, 1'b1, 5'd1);
    chk("t5_stall_ena_busy_rdy", {m_ena, busy, cmd_ready}, 3'b010);
    chk("t5_stall_no_rise", ena_rises, rises0);
    exp_bus.push_back(8'h74); exp_bus.push_back(8'hC1); exp_bus.push_back(8'hC2);
    exp_bus.push_back(8'hC3); exp_bus.push_back(8'hC4); exp_bus.push_back(STOP_TOK);
    exp_done.push_back(0);
    push_byte(8'hC4);
    wait_done("t5_done_seen", 3000);

    // Asynchronous reset during the 2nd data byte
    push_byte(8'hD1); push_byte(8'hD2); push_byte(8'hD3);
    exp_bus.push_back(8'hA0); exp_bus.push_back(8'hD1); exp_bus.push_back(8'hD2);
    et_cnt = 0;
    issue_cmd(7'h50, 1'b0, 5'd3);
    wait_et(2, 1000);
    repeat (2 * B) @(negedge clk);
    arstn = 1'b0;
    #1;
    chk("t6_ena_async", m_ena, 0);
    @(posedge clk); #1;
    chk("t6_ena_busy_rdy", {m_ena, busy, cmd_ready, wr_ready}, 4'b0011);
    @(negedge clk);
    arstn = 1'b1;

    // Fill FIFO to 16, 17th push ignored, then drain all 16
    for (int i = 0; i < 15; i++) push_byte(8'(8'h40 + i));
    chk("t7_ready_at_15", wr_ready, 1);
    push_byte(8'h4F);
    chk("t7_full_at_16", wr_ready, 0);
    push_byte(8'hEE);
    chk("t7_still_full", wr_ready, 0);
    exp_bus.push_back(8'h02);
    for (int i = 0; i < 16; i++) exp_bus.push_back(8'h40 + i);
    exp_bus.push_back(STOP_TOK);
    exp_done.push_back(0);
    issue_cmd(7'h01, 1'b0, 5'd16);
    wait_done("t7_done_seen", 4000);
    chk("t7_ready_after", wr_ready, 1);

    repeat (5) @(negedge clk);
    chk("end_bus_empty", exp_bus.size(), 0);
    chk("end_rd_empty", exp_rd.size(), 0);
    chk("end_done_empty", exp_done.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : global_timeout
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
`default_nettype wire
